qep_decoder_ch: RTL and testbench
=================================

Name: qep_decoder_ch

Overview:
- Single-channel, parametrised quadrature encoder interface for the drive subsystem, replacing the fixed 2-input edge decoder.
- Data path:
  - synchronises and glitch-filters A/B/Z;
  - decodes quadrature transitions into counts;
  - maintains a modulo-CPR position with index latch/reset and illegal-transition detection.
- Feeds the position/speed estimator and motor-control fault logic.

Parameters:
- POS_W, 32, position/CPR width in bits.
- SYNC_STAGES, 2, synchroniser flops per input (>=2).
- FILT_LEN, 4, consecutive stable samples required before a filtered input changes (>=1).
- PER_W, 24, period counter width (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- A  in  1  encoder channel A, asynchronous.
- B  in  1  encoder channel B, asynchronous.
- Z  in  1  encoder index, asynchronous.
- cpr  in  POS_W  counts per revolution (modulus); 0 = free-run modulo 2^POS_W.
- idx_reset_en  in  1  when 1, index rising edge zeroes pos.
- pos_load  in  1  one-cycle strobe: load pos_load_val into pos.
- pos_load_val  in  POS_W  load value.
- err_clr  in  1  clears err_sticky.
- pulse  out  1  one-cycle strobe per valid count.
- dir  out  1  1 = forward, 0 = reverse; holds last direction.
- pos  out  POS_W  position.
- idx_pos  out  POS_W  position captured at last index.
- idx_valid  out  1  one-cycle strobe on index capture.
- overspeed  out  1  one-cycle strobe on illegal transition (A and B change in same filtered cycle).
- err_sticky  out  1  sticky illegal-transition flag.
- period  out  PER_W  clocks between valid counts (present only with the optional feature).

Behaviour:
- Reset (reset_n=0 at clk edge):
  - All sync/filter stages, filtered A/B/Z, pulse, dir, pos, idx_pos, idx_valid, overspeed, err_sticky = 0.
  - period = all-ones (meaning "stopped").
- Sync: each input passes through SYNC_STAGES flops.
- Filter, per input:
  - Counter increments while synced value != filtered value; clears when they are equal.
  - Filtered value takes the synced value when the counter reaches FILT_LEN; the counter then clears.
  - A glitch shorter than FILT_LEN samples is rejected.
- Decode: compare previous filtered {A,B} with current, evaluated every cycle.
  - Forward sequence AB: 00->10->11->01->00.
  - Reverse sequence: the opposite order.
  - Valid step: pulse=1 for one cycle, dir updated, pos +/-1.
  - Both bits changed: no count, dir unchanged, overspeed=1 for one cycle, err_sticky=1.
  - No change: pulse=0.
- Latency: raw edge stable from clk edge k gives pulse registered at edge k+SYNC_STAGES+FILT_LEN+1. That is 7 clocks at defaults.
- Position wrap:
  - Forward from cpr-1 goes to 0; reverse from 0 goes to cpr-1.
  - cpr=0: natural 2^POS_W wrap.
  - If cpr changes while pos >= cpr, the next forward count wraps to 0; the next reverse count gives pos-1.
- Index: rising edge of filtered Z.
  - idx_pos <= position as updated by any same-cycle count; idx_valid=1 for one cycle.
  - If idx_reset_en=1, pos <= 0; this overrides a same-cycle count.
- Priority on pos: pos_load > index reset > count.
  - pos_load does not suppress the pulse, dir or idx capture from the same cycle.
- err_clr: clears err_sticky. If an illegal transition occurs in the same cycle, set wins.
- Reset mid-operation clears everything. The filters restart, so the first valid step after reset is measured from filtered state 00: if the encoder rests at AB=11, the first filtered change is illegal and flags overspeed. This is intended; software clears err_sticky after start-up.

Optional Feature:
- Macro QEP_PERIOD_MEAS_EN.
- When defined:
  - per_cnt (PER_W) increments every clock, saturating at all-ones.
  - On each pulse: period <= per_cnt+1 (saturating) and per_cnt <= 0.
  - period stays all-ones until the first pulse after reset, or while per_cnt is saturated; the saturated value signals "stalled".
- When undefined: no per_cnt logic, and the period port is absent.

Test Plan:
- Defaults, cpr=8, drive AB 00->10->11->01->00 with each state held 10 clk -> four pulses, dir=1, pos 0->4. Each pulse appears 7 clk after the raw change.
- pos=0, cpr=8, reverse sequence one step -> pos=7, dir=0. Forward from pos=7 -> pos=0.
- A glitch of 3 clk (FILT_LEN=4) -> no pulse, pos unchanged. A 4-clk hold -> one pulse.
- AB 00->11 in the same clk, held -> overspeed one cycle, err_sticky=1, pos unchanged. err_clr asserted with a new illegal step in the same cycle -> err_sticky stays 1.
- pos=5, idx_reset_en=1, Z rising edge coincident with a forward step -> idx_pos=6, idx_valid pulse, pos=0. Repeat with pos_load=1, pos_load_val=100 -> pos=100.
- With QEP_PERIOD_MEAS_EN, forward steps every 50 clk -> period=50 after the second pulse. Inputs frozen for 2^PER_W clk -> per_cnt saturates, and the next pulse gives period=all-ones.

Source files
------------

// File: rtl/qep_decoder_ch.sv
// qep_decoder_ch: single-channel quadrature decoder (synchroniser, glitch filter, x4 decode,
// modulo-CPR position, index latch). Define QEP_PERIOD_MEAS_EN to add the period output.
module qep_decoder_ch #(
    parameter int POS_W       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4,
    parameter int PER_W       = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             A,
    input  logic             B,
    input  logic             Z,
    input  logic [POS_W-1:0] cpr,
    input  logic             idx_reset_en,
    input  logic             pos_load,
    input  logic [POS_W-1:0] pos_load_val,
    input  logic             err_clr,
    output logic             pulse,
    output logic             dir,
    output logic [POS_W-1:0] pos,
    output logic [POS_W-1:0] idx_pos,
    output logic             idx_valid,
    output logic             overspeed,
    output logic             err_sticky
`ifdef QEP_PERIOD_MEAS_EN
    ,
    output logic [PER_W-1:0] period
`endif
);

    localparam int CNT_W = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN);
    localparam int A_I   = 0;
    localparam int B_I   = 1;
    localparam int Z_I   = 2;

    if (SYNC_STAGES < 2 || FILT_LEN < 1 || PER_W < 1 || POS_W < 1) begin : g_param_check
        $error("qep_decoder_ch: illegal parameter value");
    end

    logic [SYNC_STAGES-1:0][2:0] sync_q;
    logic [2:0]                  synced;
    logic [2:0][CNT_W-1:0]       filt_cnt;
    logic [2:0]                  filt;
    logic [2:0]                  filt_prev;

    assign synced = sync_q[SYNC_STAGES-1];

    // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q   <= '0;
            filt_cnt <= '0;
            filt     <= '0;
        end else begin
            sync_q[0] <= {Z, B, A};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            // The counter tracks consecutive samples disagreeing with the filtered value.
            for (int c = 0; c < 3; c++) begin
                if (synced[c] == filt[c]) begin
                    filt_cnt[c] <= '0;
                end else if (filt_cnt[c] == CNT_W'(FILT_LEN - 1)) begin
                    filt[c]     <= synced[c];
                    filt_cnt[c] <= '0;
                end else begin
                    filt_cnt[c] <= filt_cnt[c] + CNT_W'(1);
                end
            end
        end
    end

    logic [1:0]       ab_prev;
    logic [1:0]       ab_cur;
    logic             step_fwd;
    logic             step_rev;
    logic             illegal;
    logic             idx_rise;
    logic [POS_W-1:0] pos_cnt;
    logic [POS_W-1:0] pos_next;

    assign ab_prev  = {filt_prev[A_I], filt_prev[B_I]};
    assign ab_cur   = {filt[A_I], filt[B_I]};
    assign idx_rise = filt[Z_I] & ~filt_prev[Z_I];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        step_fwd = 1'b0;
        step_rev = 1'b0;
        illegal  = 1'b0;
        case ({ab_prev, ab_cur})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step_fwd = 1'b1;
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step_rev = 1'b1;
            4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: illegal  = 1'b1;
            default: ;
        endcase
    end

    // Forward wrap uses >= so a position left above a shrunken cpr still wraps to 0.
    always_comb begin
        pos_cnt = pos;
        if (step_fwd) begin
            pos_cnt = (cpr != '0 && pos >= cpr - POS_W'(1)) ? '0 : pos + POS_W'(1);
        end else if (step_rev) begin
            pos_cnt = (pos == '0) ? cpr - POS_W'(1) : pos - POS_W'(1);
        end
        pos_next = pos_cnt;
        if (idx_rise && idx_reset_en) pos_next = '0;
        if (pos_load) pos_next = pos_load_val;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            filt_prev  <= '0;
            pulse      <= 1'b0;
            dir        <= 1'b0;
            pos        <= '0;
            idx_pos    <= '0;
            idx_valid  <= 1'b0;
            overspeed  <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            filt_prev <= filt;
            pulse     <= step_fwd | step_rev;
            overspeed <= illegal;
            idx_valid <= idx_rise;
            pos       <= pos_next;
            if (step_fwd) dir <= 1'b1;
            else if (step_rev) dir <= 1'b0;
            if (idx_rise) idx_pos <= pos_cnt;
            if (illegal) err_sticky <= 1'b1;
            else if (err_clr) err_sticky <= 1'b0;
        end
    end

`ifdef QEP_PERIOD_MEAS_EN
    logic [PER_W-1:0] per_cnt;

    // An all-ones period means stopped or stalled; per_cnt saturates instead of wrapping.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            per_cnt <= '0;
            period  <= '1;
        end else if (step_fwd | step_rev) begin
            per_cnt <= '0;
            period  <= (per_cnt == '1) ? per_cnt : per_cnt + PER_W'(1);
        end else if (per_cnt != '1) begin
            per_cnt <= per_cnt + PER_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_qep_decoder_ch.sv
// tb_qep_decoder_ch: directed and randomized bench for qep_decoder_ch against a behavioural model
// built on window filtering and quadrature-index arithmetic.
module tb_qep_decoder_ch;

    localparam int SS   = 2;
    localparam int FL   = 4;
    localparam int PW   = 32;
    localparam int PERW = 24;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          A, B, Z;
    logic [PW-1:0] cpr;
    logic          idx_reset_en;
    logic          pos_load;
    logic [PW-1:0] pos_load_val;
    logic          err_clr;
    logic          pulse, dir, idx_valid, overspeed, err_sticky;
    logic [PW-1:0] pos, idx_pos;
`ifdef QEP_PERIOD_MEAS_EN
    logic [PERW-1:0] period;
`endif

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    qep_decoder_ch #(
        .POS_W(PW), .SYNC_STAGES(SS), .FILT_LEN(FL), .PER_W(PERW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .A(A), .B(B), .Z(Z), .cpr(cpr),
        .idx_reset_en(idx_reset_en), .pos_load(pos_load), .pos_load_val(pos_load_val),
        .err_clr(err_clr), .pulse(pulse), .dir(dir), .pos(pos), .idx_pos(idx_pos),
        .idx_valid(idx_valid), .overspeed(overspeed), .err_sticky(err_sticky)
`ifdef QEP_PERIOD_MEAS_EN
        , .period(period)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [SS-1:0][2:0] line;   // raw samples still travelling through the synchroniser
        logic [FL-1:0][2:0] win;    // most recent synchronised samples, newest at [0]
        logic [2:0]         filt;
        logic [2:0]         prev;
        logic               pulse;
        logic               dir;
        logic               idx_valid;
        logic               over;
        logic               err;
        logic [PW-1:0]      pos;
        logic [PW-1:0]      idx_pos;
        logic [PERW-1:0]    per_cnt;
        logic [PERW-1:0]    period;
    } model_t;

    model_t m;

    function automatic int quad_index(input logic a, input logic b);
        case ({a, b})
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic model_t model_reset();
        model_t r;
        r = '0;
        r.period = '1;
        return r;
    endfunction

    // Filter rule: a filtered bit flips once its last FL synchronised samples all disagree with it.
    function automatic model_t model_next(input model_t s, input logic [2:0] raw,
                                          input logic [PW-1:0] cpr_i, input logic ire,
                                          input logic pl, input logic [PW-1:0] plv,
                                          input logic ec);
        model_t        n;
        int            delta;
        logic          rise;
        logic          all_diff;
        logic [PW-1:0] np;
        n = s;
        delta = (quad_index(s.filt[0], s.filt[1]) - quad_index(s.prev[0], s.prev[1]) + 4) % 4;
        n.pulse = (delta == 1) || (delta == 3);
        n.over  = (delta == 2);
        np = s.pos;
        if (delta == 1) begin
            n.dir = 1'b1;
            np = (cpr_i != 0 && s.pos >= cpr_i - 1) ? '0 : s.pos + 1;
        end else if (delta == 3) begin
            n.dir = 1'b0;
            np = (s.pos == 0) ? cpr_i - 1 : s.pos - 1;
        end
        rise = s.filt[2] && !s.prev[2];
        n.idx_valid = rise;
        if (rise) n.idx_pos = np;
        if (rise && ire) np = '0;
        if (pl) np = plv;
        n.pos = np;
        if (n.over) n.err = 1'b1;
        else if (ec) n.err = 1'b0;
        if (n.pulse) begin
            n.period  = (s.per_cnt == '1) ? '1 : s.per_cnt + 1;
            n.per_cnt = '0;
        end else if (s.per_cnt != '1) begin
            n.per_cnt = s.per_cnt + 1;
        end
        n.prev = s.filt;
        for (int k = SS - 1; k > 0; k--) n.line[k] = s.line[k-1];
        n.line[0] = raw;
        for (int k = FL - 1; k > 0; k--) n.win[k] = s.win[k-1];
        n.win[0] = s.line[SS-1];
        for (int c = 0; c < 3; c++) begin
            all_diff = 1'b1;
            for (int k = 0; k < FL; k++) if (n.win[k][c] == s.filt[c]) all_diff = 1'b0;
            if (all_diff) n.filt[c] = ~s.filt[c];
        end
        return n;
    endfunction

    always @(posedge clk) begin
        if (!reset_n) m <= model_reset();
        else m <= model_next(m, {Z, B, A}, cpr, idx_reset_en, pos_load, pos_load_val, err_clr);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("pulse", pulse, m.pulse);
            check("dir", dir, m.dir);
            check("pos", pos, m.pos);
            check("idx_pos", idx_pos, m.idx_pos);
            check("idx_valid", idx_valid, m.idx_valid);
            check("overspeed", overspeed, m.over);
            check("err_sticky", err_sticky, m.err);
`ifdef QEP_PERIOD_MEAS_EN
            check("period", period, m.period);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_ab(input logic a, input logic b);
        A = a;
        B = b;
    endtask

    task automatic drive_q(input int q);
        case (q)
            0:       set_ab(1'b0, 1'b0);
            1:       set_ab(1'b1, 1'b0);
            2:       set_ab(1'b1, 1'b1);
            default: set_ab(1'b0, 1'b1);
        endcase
    endtask

    task automatic load(input logic [PW-1:0] v);
        pos_load     = 1'b1;
        pos_load_val = v;
        step();
        pos_load = 1'b0;
    endtask

    task automatic run_count(input int n, output int np, output int no);
        np = 0;
        no = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (pulse) np++;
            if (overspeed) no++;
        end
    endtask

    // Changes AB, holds it 10 clocks and checks the pulse arrives exactly 7 clocks later.
    task automatic step_latency(input string name, input logic a, input logic b);
        int lat;
        lat = -1;
        set_ab(a, b);
        for (int i = 1; i <= 10; i++) begin
            step();
            if (pulse && lat < 0) lat = i;
        end
        check(name, lat, 7);
    endtask

    initial begin
        int nps, nos, r, hold, q;
        reset_n = 1'b0;
        A = 1'b0; B = 1'b0; Z = 1'b0;
        cpr = 32'd8;
        idx_reset_en = 1'b0;
        pos_load = 1'b0;
        pos_load_val = '0;
        err_clr = 1'b0;
        step();
        chk_en = 1'b1;
        run(2);
        check("rst_pos", pos, 0);
        check("rst_dir", dir, 0);
        check("rst_err", err_sticky, 0);
        check("rst_pulse", pulse, 0);
        check("rst_idx_valid", idx_valid, 0);
        reset_n = 1'b1;
        run(5);

        // Forward sequence 00->10->11->01->00
        step_latency("lat_10", 1'b1, 1'b0);
        step_latency("lat_11", 1'b1, 1'b1);
        step_latency("lat_01", 1'b0, 1'b1);
        step_latency("lat_00", 1'b0, 1'b0);
        check("fwd_pos", pos, 4);
        check("fwd_dir", dir, 1);

        // Reverse wrap from 0 and forward wrap from cpr-1
        load(32'd0);
        set_ab(1'b0, 1'b1);
        run(10);
        check("rev_wrap_pos", pos, 7);
        check("rev_wrap_dir", dir, 0);
        set_ab(1'b0, 1'b0);
        run(10);
        check("fwd_wrap_pos", pos, 0);
        check("fwd_wrap_dir", dir, 1);

        // Glitch rejection: 3 samples rejected, 4 samples accepted (and the return step too)
        A = 1'b1;
        run(3);
        A = 1'b0;
        run_count(15, nps, nos);
        check("glitch3_pulses", nps, 0);
        check("glitch3_pos", pos, 0);
        A = 1'b1;
        run(4);
        A = 1'b0;
        run_count(20, nps, nos);
        check("glitch4_pulses", nps, 2);

        // Illegal transitions and err_clr precedence
        set_ab(1'b1, 1'b1);
        run_count(10, nps, nos);
        check("illegal_over_count", nos, 1);
        check("illegal_pulses", nps, 0);
        check("illegal_err", err_sticky, 1);
        check("illegal_pos", pos, 0);
        set_ab(1'b0, 1'b0);
        run(6);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("clr_vs_set_over", overspeed, 1);
        check("clr_vs_set_err", err_sticky, 1);
        run(3);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("clr_err", err_sticky, 0);

        // Index with coincident forward step, then with pos_load overriding
        idx_reset_en = 1'b1;
        load(32'd5);
        set_ab(1'b1, 1'b0);
        Z = 1'b1;
        run(7);
        check("idx_pulse", pulse, 1);
        check("idx_valid", idx_valid, 1);
        check("idx_pos", idx_pos, 6);
        check("idx_reset_pos", pos, 0);
        Z = 1'b0;
        run(10);
        load(32'd5);
        set_ab(1'b1, 1'b1);
        Z = 1'b1;
        run(6);
        pos_load = 1'b1;
        pos_load_val = 32'd100;
        step();
        pos_load = 1'b0;
        check("load_idx_valid", idx_valid, 1);
        check("load_idx_pos", idx_pos, 6);
        check("load_pulse", pulse, 1);
        check("load_pos", pos, 100);
        Z = 1'b0;
        idx_reset_en = 1'b0;
        run(10);

        // Position above cpr: reverse decrements, forward wraps to 0
        set_ab(1'b1, 1'b0);
        run(10);
        check("above_cpr_rev", pos, 99);
        cpr = 32'd4;
        set_ab(1'b1, 1'b1);
        run(10);
        check("above_cpr_fwd", pos, 0);

`ifdef QEP_PERIOD_MEAS_EN
        set_ab(1'b0, 1'b1);
        run(50);
        set_ab(1'b0, 1'b0);
        run(50);
        set_ab(1'b1, 1'b0);
        run(50);
        check("period_50", period, 50);
`endif

        // Randomized phase
        q = 0;
        drive_q(q);
        run(12);
        for (int seg = 0; seg < 400; seg++) begin
            r = $urandom_range(0, 9);
            if (r < 4) q = (q + 1) % 4;
            else if (r < 8) q = (q + 3) % 4;
            else if (r == 8) q = (q + 2) % 4;
            drive_q(q);
            if ($urandom_range(0, 7) == 0) Z = ~Z;
            if ($urandom_range(0, 3) == 0) idx_reset_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) begin
                case ($urandom_range(0, 5))
                    0:       cpr = 32'd0;
                    1:       cpr = 32'd1;
                    2:       cpr = 32'd2;
                    3:       cpr = 32'd3;
                    4:       cpr = 32'd13;
                    default: cpr = 32'd8;
                endcase
            end
            if ($urandom_range(0, 149) == 0) begin
                reset_n = 1'b0;
                run(2);
                reset_n = 1'b1;
            end
            hold = $urandom_range(1, 12);
            for (int i = 0; i < hold; i++) begin
                err_clr  = ($urandom_range(0, 7) == 0);
                pos_load = ($urandom_range(0, 39) == 0);
                pos_load_val = ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($urandom_range(0, 15));
                step();
            end
            err_clr  = 1'b0;
            pos_load = 1'b0;
        end
        run(20);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
